// File: rtl/core_pkg.sv
// Shared pipeline-wide constants and the fetch buffer entry type.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_if.sv
// Instruction-memory request/response bus between the prefetcher and memory.
interface instr_prefetch_if;
    import core_pkg::*;

    logic            imem_req_out;
    logic [XLEN-1:0] imem_addr_out;
    logic            imem_ready_in;
    logic            imem_resp_valid_in;
    logic [XLEN-1:0] imem_resp_data_in;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_ready_in,
        input  imem_resp_valid_in,
        input  imem_resp_data_in
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_ready_in,
        output imem_resp_valid_in,
        output imem_resp_data_in
    );

endinterface

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO with a registered head output that reads zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    next_rd;
    logic [CW-1:0]    remain;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
        remain  = count - CW'(pop_ok);
        next_rd = rd_ptr + AW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head register is reloaded from the entry that becomes the head after
    // this edge; when no older entry survives, that is the word being pushed.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= next_rd;
            end
            count <= remain + CW'(push_ok);
            if (remain == '0) begin
                head <= push_ok ? push_data : '0;
            end else begin
                head <= mem[next_rd];
            end
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Sequential-PC instruction prefetcher: issues word fetches under a credit
// limit, discards stale responses after a redirect, and buffers (pc, instr).
module instr_prefetch
    import core_pkg::*;
#(
    parameter int unsigned         DEPTH    = 4,
    parameter logic [XLEN-1:0]     RESET_PC = core_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_prefetch_if.master       imem,
    input  logic                   redirect_in,
    input  logic [XLEN-1:0]        redirect_pc_in,
    input  logic                   hazard_in,
    output logic [XLEN-1:0]        pc_out,
    output logic [XLEN-1:0]        instrn_out,
    output logic                   valid_out
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            accept;
    logic            resp_fire;
    logic            push;
    logic            pop;

    assign valid_out = (count != '0);

    // With no stale responses pending every outstanding request is live, so
    // the returning word belongs to fetch_pc minus 4 per outstanding request.
    always_comb begin
        imem.imem_req_out  = !rst && !redirect_in &&
                             (({1'b0, count} + {1'b0, outst}) < DEPTH_C);
        imem.imem_addr_out = fetch_pc;
        accept             = imem.imem_req_out && imem.imem_ready_in;
        resp_fire          = imem.imem_resp_valid_in && (outst != '0);
        push               = resp_fire && (drop == '0) && !redirect_in;
        pop                = valid_out && !hazard_in && !redirect_in;
        push_entry.pc      = fetch_pc - XLEN'({outst, 2'b00});
        push_entry.instr   = imem.imem_resp_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            outst    <= '0;
            drop     <= '0;
        end else begin
            case ({accept, resp_fire})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase
            if (redirect_in) begin
                fetch_pc <= redirect_pc_in & ~XLEN'(3);
                drop     <= outst - CW'(resp_fire);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (resp_fire && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_in),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign pc_out     = head.pc;
    assign instrn_out = valid_out ? head.instr : NOP_INSTR;

endmodule
